// File: rtl/bsg_event_counter_pkg.sv
// Shared types and helpers for the event counter bank.
//   ctr_mode_e : overflow behaviour of a channel (wrap or saturate).
//   ctr_get    : pull channel k of width w out of a packed counter bus.
//                The bus is zero-extended to ctr_bus_t by the caller.
package bsg_event_counter_pkg;

    typedef enum logic {
        e_ctr_wrap     = 1'b0,
        e_ctr_saturate = 1'b1
    } ctr_mode_e;

    localparam int ctr_max_width_lp = 64;
    localparam int ctr_max_bus_lp   = 1024;

    typedef logic [ctr_max_bus_lp-1:0] ctr_bus_t;

    function automatic logic [ctr_max_width_lp-1:0] ctr_get(
        input ctr_bus_t    bus,
        input int unsigned k,
        input int unsigned w
    );
        ctr_bus_t                    shifted;
        logic [ctr_max_width_lp-1:0] mask;
        shifted = bus >> (k * w);
        if (w >= 32'(ctr_max_width_lp)) begin
            mask = '1;
        end else begin
            mask = (ctr_max_width_lp'(1) << w) - ctr_max_width_lp'(1);
        end
        return shifted[ctr_max_width_lp-1:0] & mask;
    endfunction

endpackage

// File: rtl/bsg_event_counter_ch.sv
// One counter channel: counter register, sticky overflow flag and the
// clear > increment > hold priority.
//   clk_i, reset_n_i : clock, async active-low reset
//   inc_i            : increment request (already gated by global enable)
//   clear_i          : synchronous clear of counter and overflow flag
//   ctr_o            : registered counter value
//   ovf_o            : registered sticky overflow flag
module bsg_event_counter_ch
    import bsg_event_counter_pkg::*;
#(
    parameter int        width_p = 16,
    parameter ctr_mode_e mode_p  = e_ctr_wrap
) (
    input  logic               clk_i,
    input  logic               reset_n_i,
    input  logic               inc_i,
    input  logic               clear_i,
    output logic [width_p-1:0] ctr_o,
    output logic               ovf_o
);

    logic [width_p-1:0] ctr_d, ctr_q;
    logic               ovf_d, ovf_q;
    logic [width_p:0]   sum;

    always_comb begin
        ctr_d = ctr_q;
        ovf_d = ovf_q;
        // The carry out of the widened add is the overflow condition;
        // in wrap mode the low bits are already the wrapped value of 0.
        sum   = {1'b0, ctr_q} + (width_p+1)'(1);
        if (clear_i) begin
            ctr_d = '0;
            ovf_d = 1'b0;
        end else if (inc_i) begin
            if (sum[width_p]) begin
                ovf_d = 1'b1;
                ctr_d = (mode_p == e_ctr_saturate) ? ctr_q : sum[width_p-1:0];
            end else begin
                ctr_d = sum[width_p-1:0];
            end
        end
    end

    always_ff @(posedge clk_i or negedge reset_n_i) begin
        if (!reset_n_i) begin
            ctr_q <= '0;
            ovf_q <= 1'b0;
        end else begin
            ctr_q <= ctr_d;
            ovf_q <= ovf_d;
        end
    end

    assign ctr_o = ctr_q;
    assign ovf_o = ovf_q;

endmodule

// File: rtl/bsg_event_counter_bank.sv
// Bank of els_p independent event/cycle counters with an atomic snapshot.
//   clk_i, reset_n_i : clock, async active-low reset
//   en_i             : global count enable (clear and snapshot ignore it)
//   event_v_i        : per-channel increment request
//   clear_i          : per-channel synchronous clear
//   snap_v_i         : capture every live counter into the snapshot bus
//   ctr_r_o          : live counters, channel k at [k*width_p +: width_p]
//   ovf_r_o          : sticky overflow flag per channel
//   snap_r_o         : snapshot values, same packing as ctr_r_o
//   snap_v_o         : one-cycle pulse when snap_r_o has been refreshed
module bsg_event_counter_bank
    import bsg_event_counter_pkg::*;
#(
    parameter int width_p    = 16,
    parameter int els_p      = 4,
    parameter int saturate_p = 0
) (
    input  logic                     clk_i,
    input  logic                     reset_n_i,
    input  logic                     en_i,
    input  logic [els_p-1:0]         event_v_i,
    input  logic [els_p-1:0]         clear_i,
    input  logic                     snap_v_i,
    output logic [els_p*width_p-1:0] ctr_r_o,
    output logic [els_p-1:0]         ovf_r_o,
    output logic [els_p*width_p-1:0] snap_r_o,
    output logic                     snap_v_o
);

    localparam ctr_mode_e mode_lp = (saturate_p != 0) ? e_ctr_saturate : e_ctr_wrap;

    logic [els_p*width_p-1:0] ctr_live;
    logic [els_p-1:0]         ovf_live;

    for (genvar k = 0; k < els_p; k++) begin : g_ch
        bsg_event_counter_ch #(
            .width_p (width_p),
            .mode_p  (mode_lp)
        ) u_ch (
            .clk_i     (clk_i),
            .reset_n_i (reset_n_i),
            .inc_i     (en_i & event_v_i[k]),
            .clear_i   (clear_i[k]),
            .ctr_o     (ctr_live[k*width_p +: width_p]),
            .ovf_o     (ovf_live[k])
        );
    end

    logic [els_p*width_p-1:0] snap_d, snap_q;
    logic                     snap_v_d, snap_v_q;

    // Captures the channel registers as they stand before this edge, so a
    // simultaneous clear or increment is not visible in the snapshot.
    always_comb begin
        snap_d   = snap_q;
        snap_v_d = snap_v_i;
        if (snap_v_i) begin
            snap_d = ctr_live;
        end
    end

    always_ff @(posedge clk_i or negedge reset_n_i) begin
        if (!reset_n_i) begin
            snap_q   <= '0;
            snap_v_q <= 1'b0;
        end else begin
            snap_q   <= snap_d;
            snap_v_q <= snap_v_d;
        end
    end

    assign ctr_r_o  = ctr_live;
    assign ovf_r_o  = ovf_live;
    assign snap_r_o = snap_q;
    assign snap_v_o = snap_v_q;

endmodule

// File: doc/bsg_event_counter_bank.md
# bsg_event_counter_bank

Parametrised bank of independent event/cycle counters, the multi-channel successor to the single free-running cycle counter. Each channel counts cycles or gated events with configurable width, wrap or saturate overflow handling, a sticky overflow flag, per-channel clear, and an atomic snapshot of all channels. It sits beside the performance-monitoring and debug logic, and software or a CSR block reads it through the snapshot port.

## Interface
- `width_p`, default 16: counter width in bits per channel, minimum 2.
- `els_p`, default 4: number of channels, minimum 1.
- `saturate_p`, default 0: overflow mode. 0 means counters wrap modulo 2^width_p; 1 means counters hold at 2^width_p-1.

Ports (name, direction, width, meaning):
- `clk_i`, in, 1: clock.
- `reset_n_i`, in, 1: asynchronous, active-low reset.
- `en_i`, in, 1: global count enable (freeze when 0).
- `event_v_i`, in, els_p: per-channel increment request. A channel permanently tied high acts as a cycle counter.
- `clear_i`, in, els_p: per-channel synchronous clear.
- `snap_v_i`, in, 1: capture all counters into the snapshot registers.
- `ctr_r_o`, out, els_p*width_p: live counter values. Channel k occupies bits [k*width_p +: width_p].
- `ovf_r_o`, out, els_p: sticky overflow flag per channel.
- `snap_r_o`, out, els_p*width_p: snapshot values, using the same packing as `ctr_r_o`.
- `snap_v_o`, out, 1: one-cycle pulse marking a new snapshot.

## Operation
- Reset, when `reset_n_i` is low, acts immediately and is independent of `clk_i`:
  - `ctr_r_o`, `ovf_r_o`, `snap_r_o` and `snap_v_o` are all 0.
  - Reset asserted mid-count discards all state, including a snapshot in flight.
- Increment condition for channel k: `inc_k = en_i & event_v_i[k]`.
- Per-channel priority, evaluated at each rising edge:
  1. `clear_i[k]`: counter goes to 0 and `ovf_r_o[k]` goes to 0. Clear beats a simultaneous increment, so the result is 0, not 1.
  2. `inc_k` with counter ≠ 2^width_p-1: counter goes to counter+1.
  3. `inc_k` with counter = 2^width_p-1:
     - If `saturate_p`=0, the counter goes to 0.
     - If `saturate_p`=1, the counter holds at max.
     - In both modes `ovf_r_o[k]` goes to 1.
  4. Otherwise the counter holds.
- Overflow flag:
  - Sticky.
  - Cleared only by `clear_i[k]` or by reset.
  - In saturate mode, further increments at max keep the flag at 1.
- Width rule: each increment is computed as width_p+1 bits, and the carry-out is the overflow condition. No other arithmetic is performed.
- Snapshot:
  - On an edge where `snap_v_i`=1, `snap_r_o` captures the pre-edge values of `ctr_r_o` for all channels atomically.
  - `snap_v_o` is 1 for exactly the following cycle.
  - `snap_r_o` holds its value until the next snapshot.
  - Back-to-back `snap_v_i` gives back-to-back `snap_v_o` pulses, each one carrying fresh data.
- Simultaneous snapshot and clear/increment: the snapshot receives the pre-update value. For example, counter=5 with clear and snap in the same cycle gives snap=5 and ctr=0.
- `en_i`=0 freezes increments only. Clear and snapshot still operate.

## Timing
- All outputs are registered. There is no combinational path from any input to any output.
- Increment, clear and overflow all take effect one cycle after the input edge.
- Snapshot latency is 1 cycle from `snap_v_i` to `snap_v_o`/`snap_r_o`.
- Reset release takes effect on the first edge after `reset_n_i` rises. The first increment that is possible is therefore visible one cycle later.

## Structure
- Package `bsg_event_counter_pkg`:
  - Holds the overflow-mode enum (`e_ctr_wrap`, `e_ctr_saturate`).
  - Holds a function that extracts channel k from the packed vector.
  - `saturate_p` maps onto this enum.
- Sub-module `bsg_event_counter_ch`: one channel, containing the counter register, the overflow flag and the priority logic. It is instantiated els_p times with a generate loop.
- The snapshot registers and `snap_v_o` live in the top level, not in the channels.

## Test plan
- **Reset and basic count.** Hold reset low, then release; set `en_i`=1 and `event_v_i`=all 1s for 10 cycles. Required: all channels read 10, `ovf_r_o`=0.
- **Wrap.** Use `width_p`=4, `saturate_p`=0, and run 17 increments on channel 0 only. Required: ctr0=1, `ovf_r_o[0]`=1, other channels 0 with no overflow.
- **Saturate.** Use `width_p`=4, `saturate_p`=1, and run 20 increments. Required: ctr=15, `ovf_r_o`=1.
- **Clear priority.**
  - Set up ctr=7 with `ovf_r_o`=1.
  - Assert `clear_i` and `event_v_i` in the same cycle. Required: ctr=0 and `ovf_r_o`=0 the next cycle.
  - Continue incrementing. Required: ctr=1 one cycle later.
- **Snapshot atomicity.** Use ctr0=5 and ctr1=9, assert `snap_v_i` together with `clear_i[0]` and an increment on channel 1. Required: `snap_v_o`=1 for one cycle, `snap_r_o`={9,5}, ctr0=0, ctr1=10.
- **Freeze and async reset.**
  - Set `en_i`=0 for 5 cycles. Required: values unchanged.
  - Drop `reset_n_i` mid-cycle. Required: all outputs 0 before the next clock edge.
